// File: rtl/fetch_ctrl_if.sv
// Instruction-bus and F/D entry bundle for fetch_ctrl.
// master = fetch_ctrl, slave = ibus / predictor / F/D register side.
interface fetch_ctrl_if;
    logic [63:0] pc;
    logic        ireq_valid;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [63:0] pred_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic [63:0] out_pred_pc;

    modport master (
        output pc, ireq_valid, out_valid, out_pc, out_instr, out_misalign, out_pred_pc,
        input  iresp_data_ok, iresp_data, pred_pc
    );

    modport slave (
        input  pc, ireq_valid, out_valid, out_pc, out_instr, out_misalign, out_pred_pc,
        output iresp_data_ok, iresp_data, pred_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, holds the ibus address stable until data_ok,
// buffers entries while decode stalls, and drains in-flight responses on redirect.
// Optional macro FETCH_PERF_EN adds perf_wait_cnt / perf_drop_cnt counters.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          PERF_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    fetch_ctrl_if.master fif
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_wait_cnt,
    output logic [PERF_W-1:0] perf_drop_cnt
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    if (PERF_W < 1) begin : g_perf_w_check
        $error("fetch_ctrl: PERF_W must be at least 1");
    end

    logic [1:0]  state;
    logic [63:0] pc_q;
    logic [63:0] pend_q;
    logic [63:0] buf_pc;
    logic [31:0] buf_instr;
    logic        buf_mis;
    logic [63:0] buf_pred_pc;

    logic        redir;
    logic [63:0] tgt;
    logic        mis;
    logic        done;
    logic        ireq;

    always_comb begin
        redir = trap_valid | redirect_valid;
        tgt   = trap_valid ? trap_pc : redirect_pc;
        mis   = (pc_q[1:0] != 2'b00);
        done  = mis | fif.iresp_data_ok;
    end

    // In DRAIN the stale response must never reach F/D, but the request stays up.
    always_comb begin
        ireq             = 1'b0;
        fif.out_valid    = 1'b0;
        fif.out_pc       = pc_q;
        fif.out_instr    = mis ? 32'h0 : fif.iresp_data;
        fif.out_misalign = mis;
        fif.out_pred_pc  = fif.pred_pc;
        case (state)
            S_FETCH: begin
                ireq          = ~mis;
                fif.out_valid = done & ~redir;
            end
            S_HOLD: begin
                fif.out_valid    = ~redir;
                fif.out_pc       = buf_pc;
                fif.out_instr    = buf_instr;
                fif.out_misalign = buf_mis;
                fif.out_pred_pc  = buf_pred_pc;
            end
            S_DRAIN: begin
                ireq = 1'b1;
            end
            default: begin
                ireq = 1'b0;
            end
        endcase
        fif.pc         = pc_q;
        fif.ireq_valid = ireq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            buf_pc      <= '0;
            buf_instr   <= '0;
            buf_mis     <= 1'b0;
            buf_pred_pc <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redir && done) begin
                        pc_q <= tgt;
                    end else if (redir) begin
                        pend_q <= tgt;
                        state  <= S_DRAIN;
                    end else if (done && !stallD) begin
                        pc_q <= fif.pred_pc;
                    end else if (done) begin
                        buf_pc      <= pc_q;
                        buf_instr   <= mis ? 32'h0 : fif.iresp_data;
                        buf_mis     <= mis;
                        buf_pred_pc <= fif.pred_pc;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pc_q  <= tgt;
                        state <= S_FETCH;
                    end else if (!stallD) begin
                        pc_q  <= buf_pred_pc;
                        state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // A redirect arriving together with the response is newer than pend.
                    if (fif.iresp_data_ok) begin
                        pc_q  <= redir ? tgt : pend_q;
                        state <= S_FETCH;
                    end else if (redir) begin
                        pend_q <= tgt;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic wait_evt;
    logic drop_evt;

    always_comb begin
        wait_evt = ireq & ~fif.iresp_data_ok;
        drop_evt = (redir & (((state == S_FETCH) & done) | (state == S_HOLD)))
                 | ((state == S_DRAIN) & fif.iresp_data_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wait_cnt <= '0;
            perf_drop_cnt <= '0;
        end else begin
            if (wait_evt) perf_wait_cnt <= perf_wait_cnt + 1'b1;
            if (drop_evt) perf_drop_cnt <= perf_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an entry-level reference model.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic [63:0] pred;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallD;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        trap_valid;
    logic [63:0] trap_pc;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl_if fif ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_wait_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    fetch_ctrl #(.RESET_PC(RESET_PC), .PERF_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .stallD        (stallD),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .fif           (fif)
`ifdef FETCH_PERF_EN
        ,
        .perf_wait_cnt (perf_wait_cnt),
        .perf_drop_cnt (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic rv, input logic [63:0] rp,
                                 input logic tv, input logic [63:0] tp, input logic ok,
                                 input logic [31:0] d, input logic [63:0] pp);
        @(posedge clk);
        #1;
        reset              = r;
        stallD             = st;
        redirect_valid     = rv;
        redirect_pc        = rp;
        trap_valid         = tv;
        trap_pc            = tp;
        fif.iresp_data_ok  = ok;
        fif.iresp_data     = d;
        fif.pred_pc        = pp;
        #2;
    endtask

    // Reference model: the fetch unit is either waiting on a fresh fetch at m_pc,
    // parked on a completed entry decode has not taken, or waiting out a stale response.
    logic        m_known    = 1'b0;
    logic [63:0] m_pc       = '0;
    logic        m_parked   = 1'b0;
    entry_t      m_parked_e = '0;
    logic        m_stale    = 1'b0;
    logic [63:0] m_dest     = '0;
    logic [31:0] m_wait     = '0;
    logic [31:0] m_drop     = '0;

    always @(negedge clk) begin : compare
        logic        rd;
        logic [63:0] tg;
        logic        e_req;
        logic        e_valid;
        logic        complete;
        entry_t      e;
        rd       = trap_valid | redirect_valid;
        tg       = trap_valid ? trap_pc : redirect_pc;
        complete = 1'b0;
        e        = '0;
        if (m_stale) begin
            e_req    = 1'b1;
            e_valid  = 1'b0;
            complete = fif.iresp_data_ok;
        end else if (m_parked) begin
            e_req   = 1'b0;
            e_valid = !rd;
            e       = m_parked_e;
        end else begin
            e.pc     = m_pc;
            e.mis    = (m_pc % 4) != 0;
            e.instr  = e.mis ? 32'h0 : fif.iresp_data;
            e.pred   = fif.pred_pc;
            e_req    = !e.mis;
            complete = e.mis || fif.iresp_data_ok;
            e_valid  = complete && !rd;
        end
        if (m_known) begin
            checkOutput("model_pc", fif.pc, m_pc);
            checkOutput("model_ireq_valid", {63'h0, fif.ireq_valid}, {63'h0, e_req});
            checkOutput("model_out_valid", {63'h0, fif.out_valid}, {63'h0, e_valid});
            if (e_valid) begin
                checkOutput("model_out_pc", fif.out_pc, e.pc);
                checkOutput("model_out_instr", {32'h0, fif.out_instr}, {32'h0, e.instr});
                checkOutput("model_out_misalign", {63'h0, fif.out_misalign}, {63'h0, e.mis});
                checkOutput("model_out_pred_pc", fif.out_pred_pc, e.pred);
            end
`ifdef FETCH_PERF_EN
            checkOutput("model_perf_wait", {32'h0, perf_wait_cnt}, {32'h0, m_wait});
            checkOutput("model_perf_drop", {32'h0, perf_drop_cnt}, {32'h0, m_drop});
`endif
        end
        if (reset) begin
            m_known  = 1'b1;
            m_pc     = RESET_PC;
            m_parked = 1'b0;
            m_stale  = 1'b0;
            m_dest   = '0;
            m_wait   = '0;
            m_drop   = '0;
        end else if (m_known) begin
            if (e_req && !fif.iresp_data_ok) m_wait = m_wait + 1;
            if (m_stale) begin
                if (complete) begin
                    m_drop  = m_drop + 1;
                    m_pc    = rd ? tg : m_dest;
                    m_stale = 1'b0;
                end else if (rd) begin
                    m_dest = tg;
                end
            end else if (m_parked) begin
                if (rd) begin
                    m_drop   = m_drop + 1;
                    m_pc     = tg;
                    m_parked = 1'b0;
                end else if (!stallD) begin
                    m_pc     = m_parked_e.pred;
                    m_parked = 1'b0;
                end
            end else if (complete) begin
                if (rd) begin
                    m_drop = m_drop + 1;
                    m_pc   = tg;
                end else if (stallD) begin
                    m_parked_e = e;
                    m_parked   = 1'b1;
                end else begin
                    m_pc = e.pred;
                end
            end else if (rd) begin
                m_dest  = tg;
                m_stale = 1'b1;
            end
        end
    end

    function automatic logic [63:0] randTarget();
        logic [63:0] t;
        t = {32'h0, 32'h8000_0000 | ($urandom & 32'h0fff_fffc)};
        if ($urandom_range(99) < 15) t = t | 64'h2;
        return t;
    endfunction

    initial begin
        logic        r_rst, r_st, r_rv, r_tv, r_ok;
        logic [63:0] r_rp, r_tp, r_pp;
        int          sel;
        reset             = 1'b1;
        stallD            = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        trap_valid        = 1'b0;
        trap_pc           = '0;
        fif.iresp_data_ok = 1'b0;
        fif.iresp_data    = '0;
        fif.pred_pc       = '0;

        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Sequential fetch, one instruction per data_ok
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0011, 64'h8000_0004);
        checkOutput("reset_pc", fif.pc, 64'h8000_0000);
        checkOutput("reset_ireq", {63'h0, fif.ireq_valid}, 64'h1);
        checkOutput("seq0_valid", {63'h0, fif.out_valid}, 64'h1);
        checkOutput("seq0_instr", {32'h0, fif.out_instr}, 64'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0012, 64'h8000_0008);
        checkOutput("seq1_pc", fif.pc, 64'h8000_0004);
        checkOutput("seq1_valid", {63'h0, fif.out_valid}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0013, 64'h8000_000c);
        checkOutput("seq2_pc", fif.pc, 64'h8000_0008);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0014, 64'h8000_0010);

        // Decode stall: entry parked for three stalled cycles
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h0000_0022, 64'h8000_0014);
        checkOutput("stall_pc", fif.pc, 64'h8000_0010);
        checkOutput("stall_valid", {63'h0, fif.out_valid}, 64'h1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0, 64'h0);
        checkOutput("hold_ireq", {63'h0, fif.ireq_valid}, 64'h0);
        checkOutput("hold_out_pc", fif.out_pc, 64'h8000_0010);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h0, 64'h0);
        checkOutput("hold2_out_pc", fif.out_pc, 64'h8000_0010);
        checkOutput("hold2_instr", {32'h0, fif.out_instr}, 64'h22);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0);
        checkOutput("hold_release_valid", {63'h0, fif.out_valid}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 64'h8000_0018);
        checkOutput("after_hold_pc", fif.pc, 64'h8000_0014);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 64'h8000_001c);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 64'h8000_0020);

        // Redirect two cycles before data_ok: drain the stale response
        applyStimulus(0, 0, 1, 64'h8000_0100, 0, 0, 0, 32'h0, 64'h8000_0024);
        checkOutput("redir_pc", fif.pc, 64'h8000_0020);
        checkOutput("redir_valid", {63'h0, fif.out_valid}, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h8000_0024);
        checkOutput("drain_pc", fif.pc, 64'h8000_0020);
        checkOutput("drain_ireq", {63'h0, fif.ireq_valid}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0033, 64'h8000_0024);
        checkOutput("drain_ok_valid", {63'h0, fif.out_valid}, 64'h0);

        // Trap and redirect together with data_ok: trap wins
        applyStimulus(0, 0, 1, 64'h8000_0300, 1, 64'h8000_0200, 1, 32'h0, 64'h8000_0104);
        checkOutput("post_drain_pc", fif.pc, 64'h8000_0100);
        checkOutput("trap_valid_out", {63'h0, fif.out_valid}, 64'h0);

        // Redirect to a misaligned target
        applyStimulus(0, 0, 1, 64'h8000_0102, 0, 0, 1, 32'h0, 64'h8000_0204);
        checkOutput("trap_pc", fif.pc, 64'h8000_0200);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hdead_beef, 64'h8000_0106);
        checkOutput("mis_ireq", {63'h0, fif.ireq_valid}, 64'h0);
        checkOutput("mis_valid", {63'h0, fif.out_valid}, 64'h1);
        checkOutput("mis_flag", {63'h0, fif.out_misalign}, 64'h1);
        checkOutput("mis_instr", {32'h0, fif.out_instr}, 64'h0);
        checkOutput("mis_out_pc", fif.out_pc, 64'h8000_0102);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h8000_0300);
        checkOutput("mis_advance_pc", fif.pc, 64'h8000_0106);

        // Reset while draining
        applyStimulus(0, 0, 1, 64'h8000_0400, 0, 0, 0, 32'h0, 64'h8000_0304);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 64'h8000_0304);
        checkOutput("drain_before_reset_pc", fif.pc, 64'h8000_0300);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h8000_0004);
        checkOutput("reset_in_drain_pc", fif.pc, 64'h8000_0000);
        checkOutput("reset_in_drain_valid", {63'h0, fif.out_valid}, 64'h0);
        checkOutput("reset_in_drain_ireq", {63'h0, fif.ireq_valid}, 64'h1);
`ifdef FETCH_PERF_EN
        checkOutput("reset_perf_wait", {32'h0, perf_wait_cnt}, 64'h0);
        checkOutput("reset_perf_drop", {32'h0, perf_drop_cnt}, 64'h0);
`endif

        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(199) == 0);
            r_st  = ($urandom_range(99) < 35);
            r_rv  = ($urandom_range(99) < 8);
            r_tv  = ($urandom_range(99) < 4);
            r_rp  = randTarget();
            r_tp  = randTarget();
            r_ok  = ($urandom_range(99) < 55);
            sel   = $urandom_range(99);
            if (sel < 70)      r_pp = m_pc + 64'd4;
            else if (sel < 80) r_pp = m_pc + 64'd2;
            else               r_pp = randTarget();
            applyStimulus(r_rst, r_st, r_rv, r_rp, r_tv, r_tp, r_ok, $urandom, r_pp);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer. Owns the architectural fetch PC and drives the instruction-bus request. Guarantees the request address stays stable until data_ok. Buffers a returned instruction while decode is stalled, and sequences branch/trap redirects, including discarding a response that was already in flight when the redirect arrived. It sits between the hazard/redirect logic and the fetch datapath (PC predictor and ibus), and feeds the F/D pipeline register.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
PERF_W, 32, width of the optional performance counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stallD  in  1  decode cannot accept an instruction this cycle
redirect_valid  in  1  branch mispredict redirect from execute
redirect_pc  in  64  branch redirect target
trap_valid  in  1  exception/trap redirect from commit
trap_pc  in  64  trap target
pc  out  64  current fetch PC; drives ireq.addr and the predictor
ireq_valid  out  1  ibus request valid
iresp_data_ok  in  1  ibus response strobe, single cycle
iresp_data  in  32  ibus instruction word
pred_pc  in  64  predicted next PC for pc and iresp_data
out_valid  out  1  fetch entry valid to F/D
out_pc  out  64  PC of the entry
out_instr  out  32  instruction word; 0 when out_misalign=1
out_misalign  out  1  entry is an instruction-misaligned fault
out_pred_pc  out  64  predicted next PC of the entry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: pc=RESET_PC, state=FETCH, buffer invalid, pending target cleared. After reset, out_valid=0 and ireq_valid=(RESET_PC[1:0]==0).
- Redirect select: tgt = trap_valid ? trap_pc : redirect_pc; redir = trap_valid | redirect_valid. Trap wins when both are asserted.
- Misalign: mis = (pc[1:0] != 0). While mis, no bus request is issued and the entry completes at once ("done" = mis | iresp_data_ok).
- State FETCH:
  - ireq_valid = ~mis.
  - Outputs are a combinational passthrough: out_valid = done & ~redir. out_pc=pc, out_instr=iresp_data (0 if mis), out_misalign=mis, out_pred_pc=pred_pc.
  - redir & done: discard the entry, pc<=tgt, stay in FETCH.
  - redir & ~done & ~mis: latch pend<=tgt, go to DRAIN. pc is held.
  - ~redir & done & ~stallD: pc<=pred_pc, stay in FETCH. Back-to-back fetches achieve one instruction per data_ok.
  - ~redir & done & stallD: capture {pc, instr, mis, pred_pc} into the buffer, go to HOLD.
  - Otherwise: hold pc.
- State HOLD:
  - ireq_valid=0. out_valid=~redir. Outputs are driven from the buffer.
  - redir: drop the buffer, pc<=tgt, go to FETCH.
  - ~stallD: pc<=buffered pred_pc, clear the buffer, go to FETCH.
  - Otherwise stay in HOLD.
- State DRAIN:
  - ireq_valid=1 and pc is held at the old address; the bus contract forbids an address change mid-request.
  - out_valid=0.
  - A new redir overwrites pend with tgt; the newest target wins.
  - On iresp_data_ok: discard the data, pc<=(redir ? tgt : pend), go to FETCH.
- iresp_data_ok outside an outstanding request (HOLD, or FETCH with mis) is ignored.
- Reset asserted in any state forces the reset values on the next edge. An in-flight bus response arriving after reset is ignored only if no request is outstanding. The ibus is reset in the same cycle, so this condition holds.
- pc and tgt are used unmodified at 64 bits. No alignment masking is applied; misalignment is reported, not corrected.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_wait_cnt[PERF_W-1:0] and perf_drop_cnt[PERF_W-1:0], both 0 on reset.
  - perf_wait_cnt increments each cycle with ireq_valid & ~iresp_data_ok.
  - perf_drop_cnt increments each time a completed response or buffered entry is discarded due to a redirect.
  - Both counters wrap at 2^PERF_W.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then data_ok every cycle with pred_pc=pc+4 and stallD=0 -> pc sequence 0x80000000, 0x80000004, 0x80000008; out_valid=1 on each data_ok.
- data_ok at pc=0x80000010 while stallD=1 for 3 cycles -> HOLD: ireq_valid=0, out_pc held at 0x80000010. When stallD drops, pc becomes the buffered pred_pc 0x80000014.
- redirect_valid with redirect_pc=0x80000100 two cycles before data_ok at pc=0x80000020 -> pc stays 0x80000020 and out_valid=0 through DRAIN. After data_ok, pc=0x80000100 and the response is dropped.
- trap_valid (trap_pc=0x80000200) and redirect_valid (0x80000300) in the same cycle as data_ok -> pc=0x80000200, out_valid=0.
- Redirect to 0x80000102 -> ireq_valid=0; out_valid=1, out_misalign=1, out_instr=0 in the same cycle; pc advances to pred_pc.
- Assert reset while in DRAIN with pend=0x80000400 -> next cycle pc=RESET_PC, state FETCH, out_valid=0. With FETCH_PERF_EN defined, both counters read 0.
